// File: rtl/ins_mem_loader.sv
`default_nettype none
//==============================================================================
// Module   : ins_mem_loader
// Summary  : Writer side of the byte-addressed instruction RAM. It takes
//            32-bit words from a valid/ready stream and writes each one as
//            four bytes, big-endian, one byte per cycle.
// Options  : LOADER_CHECKSUM_EN - when defined, Checksum keeps a running
//            mod-2^32 sum of the words written in the current program.
//            When undefined, Checksum is tied to zero.
// Revision : 1.0 - initial release
//==============================================================================
module ins_mem_loader #(
  parameter int MEM_BYTES = 512,
  parameter int ADDR_W    = 9
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              WordValid,
  input  logic [31:0]       WordData,
  input  logic              WordLast,
  output logic              WordReady,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [7:0]        MemWData,
  output logic              Busy,
  output logic              Done,
  output logic              Overflow,
  output logic [ADDR_W-2:0] WordCount,
  output logic [31:0]       Checksum
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_WRITE  = 2'd1;
  localparam logic [1:0] c_FINISH = 2'd2;

  // One extra bit so the pointer can sit at MEM_BYTES once memory is full.
  localparam logic [ADDR_W:0] c_MEM_END = (ADDR_W+1)'(MEM_BYTES);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W:0]   r_wr_ptr;
  logic [1:0]        r_byte_idx;
  logic [31:0]       r_word;
  logic              r_last;
  logic              r_overflow;
  logic [ADDR_W-2:0] r_word_cnt;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [7:0]        r_data_hold;

  logic              w_room;
  logic              w_hs;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [7:0]        w_wr_byte;

  assign w_room    = (r_wr_ptr < c_MEM_END);
  assign w_hs      = (r_state == c_IDLE) && WordValid;
  assign w_wr_addr = r_wr_ptr[ADDR_W-1:0] + ADDR_W'(r_byte_idx);

  // Pick the byte for the current write, most significant byte first.
  always_comb begin
    w_wr_byte = r_word[31:24];
    case (r_byte_idx)
      2'd0:    w_wr_byte = r_word[31:24];
      2'd1:    w_wr_byte = r_word[23:16];
      2'd2:    w_wr_byte = r_word[15:8];
      default: w_wr_byte = r_word[7:0];
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) r_state <= c_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: a dropped last word still has to end the program.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (WordValid) begin
          if (w_room)        w_state_nxt = c_WRITE;
          else if (WordLast) w_state_nxt = c_FINISH;
        end
      end
      c_WRITE: begin
        if (r_byte_idx == 2'd3) w_state_nxt = r_last ? c_FINISH : c_IDLE;
      end
      c_FINISH: w_state_nxt = c_IDLE;
      default:  w_state_nxt = c_IDLE;
    endcase
  end

  // State-decoded outputs; address and data hold their last value between bursts.
  always_comb begin
    WordReady = (r_state == c_IDLE);
    Busy      = (r_state == c_WRITE);
    MemWe     = (r_state == c_WRITE);
    Done      = (r_state == c_FINISH);
    MemAddr   = (r_state == c_WRITE) ? w_wr_addr : r_addr_hold;
    MemWData  = (r_state == c_WRITE) ? w_wr_byte : r_data_hold;
  end

  // Word latch, byte sequencing, write pointer and word count.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_wr_ptr    <= '0;
      r_byte_idx  <= 2'd0;
      r_word      <= 32'h0;
      r_last      <= 1'b0;
      r_overflow  <= 1'b0;
      r_word_cnt  <= '0;
      r_addr_hold <= '0;
      r_data_hold <= 8'h0;
    end else begin
      if (w_hs) begin
        r_word     <= WordData;
        r_last     <= WordLast;
        r_byte_idx <= 2'd0;
        if (!w_room) r_overflow <= 1'b1;
      end
      if (r_state == c_WRITE) begin
        r_byte_idx  <= r_byte_idx + 2'd1;
        r_addr_hold <= w_wr_addr;
        r_data_hold <= w_wr_byte;
        if (r_byte_idx == 2'd3) begin
          r_wr_ptr   <= r_wr_ptr + (ADDR_W+1)'(4);
          r_word_cnt <= r_word_cnt + (ADDR_W-1)'(1);
        end
      end
      if (r_state == c_FINISH) begin
        r_wr_ptr   <= '0;
        r_word_cnt <= '0;
      end
    end
  end

  assign Overflow  = r_overflow;
  assign WordCount = r_word_cnt;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;
  logic        r_new_prog;

  // Running sum of written words; the first handshake of a program restarts it.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_checksum <= 32'h0;
      r_new_prog <= 1'b1;
    end else begin
      if (w_hs) begin
        r_new_prog <= 1'b0;
        if (r_new_prog)  r_checksum <= w_room ? WordData : 32'h0;
        else if (w_room) r_checksum <= r_checksum + WordData;
      end
      if (r_state == c_FINISH) r_new_prog <= 1'b1;
    end
  end

  assign Checksum = r_checksum;
`else
  assign Checksum = 32'h0;
`endif

endmodule
`default_nettype wire
